// File: rtl/tlb_op_ctrl.sv
// Sequencer for LoongArch TLB management ops (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB).
// Latency: SRCH completes 2 cycles after accept, every other op (and illegal ops) 1 cycle.
// Backpressure: op_ready is high only in IDLE; op_valid is ignored while an op is in flight.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  output logic            op_ready,
  output logic            op_done,
  output logic            op_inv_err,
  input  logic [4:0]      inv_op_in,
  input  logic [9:0]      inv_asid_in,
  input  logic [18:0]     inv_vpn_in,
  input  logic [31:0]     csr_tlbidx,
  input  logic [31:0]     csr_tlbehi,
  output logic            srch_active,
  output logic [31:0]     srch_vaddr,
  input  logic            srch_found,
  input  logic [IDXW-1:0] srch_index,
  output logic            tlbfill_en,
  output logic            tlbwr_en,
  output logic [IDXW-1:0] rand_index,
  output logic            invtlb_en,
  output logic [4:0]      invtlb_op,
  output logic [9:0]      invtlb_asid,
  output logic [18:0]     invtlb_vpn,
  input  logic [31:0]     rd_tlbehi,
  input  logic [31:0]     rd_tlbelo0,
  input  logic [31:0]     rd_tlbelo1,
  input  logic [31:0]     rd_tlbidx,
  input  logic [9:0]      rd_asid,
  output logic            csr_tlbidx_we,
  output logic [31:0]     csr_tlbidx_wdata,
  output logic            csr_tlbrd_we,
  output logic [31:0]     csr_tlbehi_wdata,
  output logic [31:0]     csr_tlbelo0_wdata,
  output logic [31:0]     csr_tlbelo1_wdata,
  output logic [9:0]      csr_asid_wdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SRCH     = 3'd1,
    SWAIT    = 3'd2,
    EXEC     = 3'd3,
    DONE_ERR = 3'd4
  } state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  state_t      state;
  logic [2:0]  op_q;
  logic [4:0]  inv_op_q;
  logic [9:0]  inv_asid_q;
  logic [18:0] inv_vpn_q;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        fill_hold;

  // Bits of the CSR/read-port words that this block never consumes.
  logic unused_bits;
  assign unused_bits = ^{rd_tlbidx[30], rd_tlbidx[23:0], csr_tlbehi[12:0]};

  // Op sequencing: operands are captured at accept; each state lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= 3'd0;
      inv_op_q   <= 5'd0;
      inv_asid_q <= 10'd0;
      inv_vpn_q  <= 19'd0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_q       <= op_code;
            inv_op_q   <= inv_op_in;
            inv_asid_q <= inv_asid_in;
            inv_vpn_q  <= inv_vpn_in;
            if (op_code == OP_SRCH)
              state <= SRCH;
            else if (op_code == OP_RD || op_code == OP_WR || op_code == OP_FILL)
              state <= EXEC;
            else if (op_code == OP_INV && inv_op_in <= 5'd6)
              state <= EXEC;
            else
              state <= DONE_ERR;
          end
        end
        SRCH:    state <= SWAIT;
        SWAIT:   state <= IDLE;
        EXEC:    state <= IDLE;
        DONE_ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Fill index: free-running x^16+x^14+x^13+x^11 LFSR, frozen while a fill is writing
  // so the entry chosen is the one the translation unit sees for the whole pulse.
  assign fill_hold = (state == EXEC) && (op_q == OP_FILL);
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rand_index = lfsr[IDXW-1:0];

  // LFSR state update; a nonzero seed keeps it off the all-zero lockup state.
  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= 16'h0001;
    else if (!fill_hold)
      lfsr <= {lfsr[14:0], lfsr_fb};
  end

  assign invtlb_op   = inv_op_q;
  assign invtlb_asid = inv_asid_q;
  assign invtlb_vpn  = inv_vpn_q;
  assign op_ready    = (state == IDLE);

  // State-decoded strobes and write data; everything is masked during reset so an
  // abandoned op leaves no trace in the CSRs or the TLB.
  always_comb begin
    op_done           = 1'b0;
    op_inv_err        = 1'b0;
    srch_active       = 1'b0;
    srch_vaddr        = 32'd0;
    tlbfill_en        = 1'b0;
    tlbwr_en          = 1'b0;
    invtlb_en         = 1'b0;
    csr_tlbidx_we     = 1'b0;
    csr_tlbidx_wdata  = 32'd0;
    csr_tlbrd_we      = 1'b0;
    csr_tlbehi_wdata  = 32'd0;
    csr_tlbelo0_wdata = 32'd0;
    csr_tlbelo1_wdata = 32'd0;
    csr_asid_wdata    = 10'd0;
    if (!reset) begin
      case (state)
        SRCH: begin
          srch_active = 1'b1;
          srch_vaddr  = {csr_tlbehi[31:13], 13'd0};
        end
        SWAIT: begin
          op_done          = 1'b1;
          csr_tlbidx_we    = 1'b1;
          csr_tlbidx_wdata = csr_tlbidx;
          if (srch_found) begin
            csr_tlbidx_wdata[31]       = 1'b0;
            csr_tlbidx_wdata[IDXW-1:0] = srch_index;
          end else begin
            csr_tlbidx_wdata[31] = 1'b1;
          end
        end
        EXEC: begin
          op_done = 1'b1;
          case (op_q)
            OP_RD: begin
              csr_tlbrd_we  = 1'b1;
              csr_tlbidx_we = 1'b1;
              if (!rd_tlbidx[31]) begin
                csr_tlbehi_wdata  = rd_tlbehi;
                csr_tlbelo0_wdata = rd_tlbelo0;
                csr_tlbelo1_wdata = rd_tlbelo1;
                csr_asid_wdata    = rd_asid;
                csr_tlbidx_wdata  = {1'b0, csr_tlbidx[30], rd_tlbidx[29:24], csr_tlbidx[23:0]};
              end else begin
                csr_tlbidx_wdata  = {1'b1, csr_tlbidx[30], 6'd0, csr_tlbidx[23:0]};
              end
            end
            OP_WR:   tlbwr_en   = 1'b1;
            OP_FILL: tlbfill_en = 1'b1;
            OP_INV:  invtlb_en  = 1'b1;
            default: ;
          endcase
        end
        DONE_ERR: begin
          op_done    = 1'b1;
          op_inv_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: each step drives inputs just after a rising edge
// and checks outputs once they settle, well clear of the next edge.
// Expected values are hand-computed constants.
module tb_tlb_op_ctrl;

  localparam int TLBNUM = 16;
  localparam int IDXW = $clog2(TLBNUM);

  logic            clk = 1'b0;
  logic            reset;
  logic            op_valid;
  logic [2:0]      op_code;
  logic            op_ready, op_done, op_inv_err;
  logic [4:0]      inv_op_in;
  logic [9:0]      inv_asid_in;
  logic [18:0]     inv_vpn_in;
  logic [31:0]     csr_tlbidx, csr_tlbehi;
  logic            srch_active;
  logic [31:0]     srch_vaddr;
  logic            srch_found;
  logic [IDXW-1:0] srch_index;
  logic            tlbfill_en, tlbwr_en;
  logic [IDXW-1:0] rand_index;
  logic            invtlb_en;
  logic [4:0]      invtlb_op;
  logic [9:0]      invtlb_asid;
  logic [18:0]     invtlb_vpn;
  logic [31:0]     rd_tlbehi, rd_tlbelo0, rd_tlbelo1, rd_tlbidx;
  logic [9:0]      rd_asid;
  logic            csr_tlbidx_we;
  logic [31:0]     csr_tlbidx_wdata;
  logic            csr_tlbrd_we;
  logic [31:0]     csr_tlbehi_wdata, csr_tlbelo0_wdata, csr_tlbelo1_wdata;
  logic [9:0]      csr_asid_wdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .op_done(op_done), .op_inv_err(op_inv_err),
    .inv_op_in(inv_op_in), .inv_asid_in(inv_asid_in), .inv_vpn_in(inv_vpn_in),
    .csr_tlbidx(csr_tlbidx), .csr_tlbehi(csr_tlbehi),
    .srch_active(srch_active), .srch_vaddr(srch_vaddr),
    .srch_found(srch_found), .srch_index(srch_index),
    .tlbfill_en(tlbfill_en), .tlbwr_en(tlbwr_en), .rand_index(rand_index),
    .invtlb_en(invtlb_en), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
    .invtlb_vpn(invtlb_vpn),
    .rd_tlbehi(rd_tlbehi), .rd_tlbelo0(rd_tlbelo0), .rd_tlbelo1(rd_tlbelo1),
    .rd_tlbidx(rd_tlbidx), .rd_asid(rd_asid),
    .csr_tlbidx_we(csr_tlbidx_we), .csr_tlbidx_wdata(csr_tlbidx_wdata),
    .csr_tlbrd_we(csr_tlbrd_we), .csr_tlbehi_wdata(csr_tlbehi_wdata),
    .csr_tlbelo0_wdata(csr_tlbelo0_wdata), .csr_tlbelo1_wdata(csr_tlbelo1_wdata),
    .csr_asid_wdata(csr_asid_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 3'd0;
    inv_op_in = 5'd0; inv_asid_in = 10'd0; inv_vpn_in = 19'd0;
    csr_tlbidx = 32'd0; csr_tlbehi = 32'd0;
    srch_found = 1'b0; srch_index = '0;
    rd_tlbehi = 32'd0; rd_tlbelo0 = 32'd0; rd_tlbelo1 = 32'd0;
    rd_tlbidx = 32'd0; rd_asid = 10'd0;

    // Reset state
    tick(); tick(); settle();
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_done", 32'(op_done), 32'd0);
    check("rst_idx_we", 32'(csr_tlbidx_we), 32'd0);
    check("rst_idx_wdata", csr_tlbidx_wdata, 32'd0);
    check("rst_fill", 32'(tlbfill_en), 32'd0);
    check("rst_inv_op", 32'(invtlb_op), 32'd0);
    check("rst_rand", 32'(rand_index), 32'd1);

    // FILL accepted on the 3rd edge after reset: lfsr 0001 -> 0002 -> 0004 -> 0008
    reset = 1'b0;
    tick(); tick();
    op_valid = 1'b1; op_code = 3'd3;
    tick(); op_valid = 1'b0; settle();
    check("fill_en", 32'(tlbfill_en), 32'd1);
    check("fill_rand", 32'(rand_index), 32'd8);
    check("fill_done", 32'(op_done), 32'd1);
    check("fill_ready", 32'(op_ready), 32'd0);
    check("fill_wr", 32'(tlbwr_en), 32'd0);
    tick(); settle();
    check("fill_en_off", 32'(tlbfill_en), 32'd0);
    check("fill_rand_held", 32'(rand_index), 32'd8);
    check("fill_ready_back", 32'(op_ready), 32'd1);

    // SRCH hit
    csr_tlbehi = 32'h1234_6000; csr_tlbidx = 32'h8000_00F0;
    op_valid = 1'b1; op_code = 3'd0;
    tick(); op_valid = 1'b0; settle();
    check("srch_active", 32'(srch_active), 32'd1);
    check("srch_vaddr", srch_vaddr, 32'h1234_6000);
    check("srch_no_done", 32'(op_done), 32'd0);
    srch_found = 1'b1; srch_index = 4'd5;
    tick(); settle();
    check("hit_we", 32'(csr_tlbidx_we), 32'd1);
    check("hit_wdata", csr_tlbidx_wdata, 32'h0000_00F5);
    check("hit_done", 32'(op_done), 32'd1);
    check("hit_active_off", 32'(srch_active), 32'd0);
    tick(); settle();
    check("hit_we_off", 32'(csr_tlbidx_we), 32'd0);
    check("hit_ready", 32'(op_ready), 32'd1);

    // SRCH miss
    csr_tlbidx = 32'h0C00_0003; srch_found = 1'b0; srch_index = 4'd9;
    op_valid = 1'b1; op_code = 3'd0;
    tick(); op_valid = 1'b0; settle();
    check("miss_no_done_1", 32'(op_done), 32'd0);
    tick(); settle();
    check("miss_done_2", 32'(op_done), 32'd1);
    check("miss_we", 32'(csr_tlbidx_we), 32'd1);
    check("miss_wdata", csr_tlbidx_wdata, 32'h8C00_0003);
    tick();

    // RD of an invalid entry
    csr_tlbidx = 32'h4C00_0007; rd_tlbidx = 32'hBF00_0000;
    rd_tlbehi = 32'hABCD_E000; rd_tlbelo0 = 32'h1111_1111;
    rd_tlbelo1 = 32'h2222_2222; rd_asid = 10'h3FF;
    op_valid = 1'b1; op_code = 3'd1;
    tick(); op_valid = 1'b0; settle();
    check("rdne_rd_we", 32'(csr_tlbrd_we), 32'd1);
    check("rdne_ehi", csr_tlbehi_wdata, 32'd0);
    check("rdne_elo0", csr_tlbelo0_wdata, 32'd0);
    check("rdne_elo1", csr_tlbelo1_wdata, 32'd0);
    check("rdne_asid", 32'(csr_asid_wdata), 32'd0);
    check("rdne_idx_we", 32'(csr_tlbidx_we), 32'd1);
    check("rdne_idx", csr_tlbidx_wdata, 32'hC000_0007);
    check("rdne_done", 32'(op_done), 32'd1);
    tick();

    // RD of a valid entry: PS from the read port, NE cleared
    rd_tlbidx = 32'h0E00_0000;
    op_valid = 1'b1; op_code = 3'd1;
    tick(); op_valid = 1'b0; settle();
    check("rd_ehi", csr_tlbehi_wdata, 32'hABCD_E000);
    check("rd_elo1", csr_tlbelo1_wdata, 32'h2222_2222);
    check("rd_asid", 32'(csr_asid_wdata), 32'h3FF);
    check("rd_idx", csr_tlbidx_wdata, 32'h4E00_0007);
    tick();

    // WR
    op_valid = 1'b1; op_code = 3'd2;
    tick(); op_valid = 1'b0; settle();
    check("wr_en", 32'(tlbwr_en), 32'd1);
    check("wr_idx_we", 32'(csr_tlbidx_we), 32'd0);
    tick(); settle();
    check("wr_en_off", 32'(tlbwr_en), 32'd0);

    // INV with illegal inv_op, then illegal op_code
    op_valid = 1'b1; op_code = 3'd4; inv_op_in = 5'd7;
    tick(); op_valid = 1'b0; settle();
    check("inv7_done", 32'(op_done), 32'd1);
    check("inv7_err", 32'(op_inv_err), 32'd1);
    check("inv7_en", 32'(invtlb_en), 32'd0);
    tick();
    op_valid = 1'b1; op_code = 3'd6;
    tick(); op_valid = 1'b0; settle();
    check("op6_err", 32'(op_inv_err), 32'd1);
    check("op6_wr", 32'(tlbwr_en), 32'd0);
    tick();

    // Legal INV; operands change after accept to prove they were registered
    op_valid = 1'b1; op_code = 3'd4;
    inv_op_in = 5'd5; inv_asid_in = 10'h3; inv_vpn_in = 19'h1;
    tick(); op_valid = 1'b0;
    inv_op_in = 5'd0; inv_asid_in = 10'h155; inv_vpn_in = 19'h7FFFF; settle();
    check("inv_en", 32'(invtlb_en), 32'd1);
    check("inv_err", 32'(op_inv_err), 32'd0);
    check("inv_op", 32'(invtlb_op), 32'd5);
    check("inv_asid", 32'(invtlb_asid), 32'h3);
    check("inv_vpn", 32'(invtlb_vpn), 32'h1);
    tick(); settle();
    check("inv_en_off", 32'(invtlb_en), 32'd0);

    // Reset asserted while in SWAIT
    csr_tlbidx = 32'h0000_0002; srch_found = 1'b1; srch_index = 4'd3;
    op_valid = 1'b1; op_code = 3'd0;
    tick(); op_valid = 1'b0;
    tick();
    reset = 1'b1; settle();
    check("rstmid_we", 32'(csr_tlbidx_we), 32'd0);
    check("rstmid_done", 32'(op_done), 32'd0);
    tick(); reset = 1'b0; settle();
    check("rstmid_ready", 32'(op_ready), 32'd1);
    check("rstmid_done_after", 32'(op_done), 32'd0);

    // op_valid held across a busy SRCH: exactly one accept
    op_valid = 1'b1; op_code = 3'd0;
    tick(); settle();
    check("hold_busy", 32'(op_ready), 32'd0);
    tick(); settle();
    check("hold_done", 32'(op_done), 32'd1);
    tick(); settle();
    check("hold_ready", 32'(op_ready), 32'd1);
    check("hold_no_srch", 32'(srch_active), 32'd0);
    op_valid = 1'b0;
    tick(); settle();
    check("hold_idle", 32'(op_ready), 32'd1);
    check("hold_no_srch2", 32'(srch_active), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
